// File: rtl/hub75_scan_driver.sv
// -----------------------------------------------------------------------------
// hub75_scan_driver
//
// Sequential scan controller for a 64x64 HUB75 panel built as two 32-line
// halves. For every scan line it walks the column address across a
// combinational pattern source, captures the six pixel bits and shifts them
// into the panel. It then blanks the panel, latches the shifted line and
// lights it for a fixed on-time.
//
// Every output is registered. Each output value describes the cycle in which
// it is visible.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   enable                   run scanning; looked at only in IDLE and when a
//                            line's display time ends
//   line[4:0], column[5:0]   address presented to the pattern source
//   r1,g1,b1,r2,g2,b2        pixel bits from the source (upper/lower half)
//   hub_clk, hub_lat         panel shift clock and latch
//   hub_oe_n                 panel output enable, active low
//   hub_addr[4:0]            panel row address
//   hub_r1 .. hub_b2         registered panel data
//   frame_start              one-cycle pulse on the first shift cycle of line 0
// -----------------------------------------------------------------------------
module hub75_scan_driver #(
    parameter int COLS         = 64,
    parameter int LINES        = 32,
    parameter int CLK_DIV      = 1,
    parameter int BLANK_CYCLES = 2,
    parameter int ON_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [4:0] line,
    output logic [5:0] column,
    input  logic       r1,
    input  logic       g1,
    input  logic       b1,
    input  logic       r2,
    input  logic       g2,
    input  logic       b2,
    output logic       hub_clk,
    output logic       hub_lat,
    output logic       hub_oe_n,
    output logic [4:0] hub_addr,
    output logic       hub_r1,
    output logic       hub_g1,
    output logic       hub_b1,
    output logic       hub_r2,
    output logic       hub_g2,
    output logic       hub_b2,
    output logic       frame_start
);

    // One shared down-phase counter serves the clock divider, blank time and
    // on time, so it is sized for the largest of the three.
    localparam int MAX_A = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int MAX_P = (MAX_A > ON_CYCLES) ? MAX_A : ON_CYCLES;
    localparam int CNT_W = (MAX_P < 2) ? 1 : $clog2(MAX_P);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [5:0]       COL_LAST   = 6'(COLS - 1);
    localparam logic [4:0]       LINE_LAST  = 5'(LINES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             phase_r;     // 0: low half of the column slot, 1: high half
    logic [4:0]       line_next_s;

    // Line address after the current one, wrapping at the last line.
    always_comb begin
        line_next_s = 5'd0;
        if (line == LINE_LAST) begin
            line_next_s = 5'd0;
        end else begin
            line_next_s = line + 5'd1;
        end
    end

    // Scan state machine; all panel and source-address outputs are updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            phase_r     <= 1'b0;
            line        <= 5'd0;
            column      <= 6'd0;
            hub_clk     <= 1'b0;
            hub_lat     <= 1'b0;
            hub_oe_n    <= 1'b1;
            hub_addr    <= 5'd0;
            {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} <= 6'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state_r)
                IDLE: begin
                    hub_clk  <= 1'b0;
                    hub_lat  <= 1'b0;
                    hub_oe_n <= 1'b1;
                    column   <= 6'd0;
                    cnt_r    <= '0;
                    phase_r  <= 1'b0;
                    {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} <= 6'd0;
                    if (enable) begin
                        state_r     <= SHIFT;
                        frame_start <= (line == 5'd0);
                    end else begin
                        state_r <= IDLE;
                    end
                end

                SHIFT: begin
                    hub_oe_n <= 1'b1;
                    hub_lat  <= 1'b0;
                    if (!phase_r) begin
                        // column has been stable since the slot began, so the
                        // source output is settled on the first low cycle.
                        if (cnt_r == '0) begin
                            {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} <= {r1, g1, b1, r2, g2, b2};
                        end
                        if (cnt_r == DIV_LAST) begin
                            phase_r <= 1'b1;
                            cnt_r   <= '0;
                            hub_clk <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        if (cnt_r == DIV_LAST) begin
                            phase_r <= 1'b0;
                            cnt_r   <= '0;
                            hub_clk <= 1'b0;
                            if (column == COL_LAST) begin
                                column   <= 6'd0;
                                state_r  <= BLANK;
                                // Row address moves only while the panel is dark.
                                hub_addr <= line;
                            end else begin
                                column <= column + 6'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end

                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        cnt_r   <= '0;
                        state_r <= LATCH;
                        hub_lat <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                LATCH: begin
                    hub_lat  <= 1'b0;
                    hub_oe_n <= 1'b0;
                    cnt_r    <= '0;
                    state_r  <= DISPLAY;
                end

                DISPLAY: begin
                    if (cnt_r == ON_LAST) begin
                        cnt_r    <= '0;
                        hub_oe_n <= 1'b1;
                        line     <= line_next_s;
                        if (enable) begin
                            state_r     <= SHIFT;
                            frame_start <= (line_next_s == 5'd0);
                        end else begin
                            state_r <= IDLE;
                            {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} <= 6'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                default: begin
                    state_r  <= IDLE;
                    hub_clk  <= 1'b0;
                    hub_lat  <= 1'b0;
                    hub_oe_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// -----------------------------------------------------------------------------
// Directed testbench for hub75_scan_driver with default parameters.
// A small combinational pattern source answers the DUT's line/column address.
// Expected panel activity for each cycle of a line is derived from the cycle's
// position in the 135-cycle line period.
// -----------------------------------------------------------------------------
module tb_hub75_scan_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] line;
    logic [5:0] column;
    logic       r1, g1, b1, r2, g2, b2;
    logic       hub_clk, hub_lat, hub_oe_n;
    logic [4:0] hub_addr;
    logic       hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic       frame_start;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [4:0] prev_addr;
    int         last_lat;
    bit         have_lat;
    int         last_fs;
    bit         have_fs;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Test pattern {r1,g1,b1,r2,g2,b2}; on line 0 r1 turns on at column 25.
    function automatic logic [5:0] pix(input logic [4:0] l, input logic [5:0] c);
        logic pr1, pg1, pb1, pr2, pg2, pb2;
        pr1 = (c >= 6'd25) ^ l[0];
        pg1 = c[0];
        pb1 = l[1] ^ c[2];
        pr2 = c[5] ^ l[2];
        pg2 = 1'b0;
        pb2 = (l == c[4:0]);
        return {pr1, pg1, pb1, pr2, pg2, pb2};
    endfunction

    assign {r1, g1, b1, r2, g2, b2} = pix(line, column);

    hub75_scan_driver dut (
        .clk(clk), .rst(rst), .enable(enable),
        .line(line), .column(column),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
        .hub_addr(hub_addr),
        .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
        .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
        .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [5:0] hub_data();
        return {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2};
    endfunction

    // Check one full line period starting at its first SHIFT cycle (we are at
    // a negedge). drop_t: cycle where enable is released; abort_t: cycle at
    // which rst is raised and the task returns one cycle later.
    task automatic run_line(input logic [4:0] l, input int drop_t, input int abort_t);
        int rises;
        logic pclk;
        rises = 0;
        pclk  = 1'b0;
        for (int t = 0; t < 135; t++) begin
            chk("line", 32'(line), 32'(l));
            chk("frame_start", 32'(frame_start), 32'((t == 0) && (l == 5'd0)));
            if (t < 128) begin
                chk("hub_clk", 32'(hub_clk), 32'(t % 2));
                chk("column", 32'(column), 32'(t / 2));
                chk("oe_shift", 32'(hub_oe_n), 32'd1);
                chk("lat_shift", 32'(hub_lat), 32'd0);
                chk("addr_shift", 32'(hub_addr), 32'(prev_addr));
                if ((t % 2) == 1) begin
                    chk("data", 32'(hub_data()), 32'(pix(l, 6'(t / 2))));
                    chk("g2_zero", 32'(hub_g2), 32'd0);
                end
                if ((l == 5'd0) && (t == 49)) chk("r1_col24", 32'(hub_r1), 32'd0);
                if ((l == 5'd0) && (t == 51)) chk("r1_col25", 32'(hub_r1), 32'd1);
            end else begin
                chk("hub_clk_idle", 32'(hub_clk), 32'd0);
                chk("column_end", 32'(column), 32'd0);
                chk("addr_hold", 32'(hub_addr), 32'(l));
                chk("data_hold", 32'(hub_data()), 32'(pix(l, 6'd63)));
                chk("lat", 32'(hub_lat), 32'(t == 130));
                chk("oe", 32'(hub_oe_n), 32'(t < 131));
            end
            if (hub_clk && !pclk) rises++;
            pclk = hub_clk;
            if ((t == 0) && (l == 5'd0) && frame_start) begin
                if (have_fs) chk("frame_period", 32'(cyc - last_fs), 32'd4320);
                last_fs = cyc;
                have_fs = 1'b1;
            end
            if ((t == 130) && hub_lat) begin
                if (have_lat) chk("lat_period", 32'(cyc - last_lat), 32'd135);
                last_lat = cyc;
                have_lat = 1'b1;
            end
            if (t == 134) chk("clk_rises", 32'(rises), 32'd64);
            if (t == drop_t) enable = 1'b0;
            if (t == abort_t) begin
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        prev_addr = l;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_oe"}, 32'(hub_oe_n), 32'd1);
        chk({tag, "_lat"}, 32'(hub_lat), 32'd0);
        chk({tag, "_clk"}, 32'(hub_clk), 32'd0);
        chk({tag, "_line"}, 32'(line), 32'd0);
        chk({tag, "_column"}, 32'(column), 32'd0);
        chk({tag, "_addr"}, 32'(hub_addr), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_data"}, 32'(hub_data()), 32'd0);
    endtask

    initial begin
        have_lat  = 1'b0;
        have_fs   = 1'b0;
        last_lat  = 0;
        last_fs   = 0;
        prev_addr = 5'd0;

        // Reset held for three cycles with enable already high.
        rst    = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        // Release: the next cycle is the first SHIFT cycle of line 0.
        rst = 1'b0;
        @(negedge clk);

        // One full frame, wrap to line 0, then lines 1..5 of the next frame;
        // enable drops during column 10 of line 5.
        for (int k = 0; k < 38; k++) begin
            run_line(5'(k % 32), (k == 37) ? 20 : -1, -1);
        end

        // Line 5 finished completely; now idle at line 6.
        chk("idle_oe", 32'(hub_oe_n), 32'd1);
        chk("idle_line", 32'(line), 32'd6);
        chk("idle_addr", 32'(hub_addr), 32'd5);
        chk("idle_clk", 32'(hub_clk), 32'd0);
        chk("idle_lat", 32'(hub_lat), 32'd0);
        chk("idle_column", 32'(column), 32'd0);
        chk("idle_data", 32'(hub_data()), 32'd0);
        repeat (4) @(negedge clk);
        chk("idle_hold_oe", 32'(hub_oe_n), 32'd1);
        chk("idle_hold_line", 32'(line), 32'd6);
        chk("idle_hold_clk", 32'(hub_clk), 32'd0);
        chk("idle_hold_fs", 32'(frame_start), 32'd0);

        // Re-enable: resumes at line 6 without a frame_start pulse.
        have_lat = 1'b0;
        enable   = 1'b1;
        @(negedge clk);
        run_line(5'd6, -1, -1);
        // Reset lands during the display time of line 7.
        run_line(5'd7, -1, 132);
        chk_reset_vals("abort");

        // Stay idle after reset with enable low.
        rst    = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_idle_oe", 32'(hub_oe_n), 32'd1);
        chk("post_idle_clk", 32'(hub_clk), 32'd0);
        chk("post_idle_line", 32'(line), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
